rv_instr_encoder: RTL
=====================

Name: rv_instr_encoder

Overview:
- Streaming RV32IMF instruction encoder: the inverse of the main opcode decoder.
- Accepts field-level encode requests (format, opcode, register indices, functs, immediate) on a valid/ready interface.
- Range-checks fields, packs them into 32-bit instruction words, tags each word with an issue address, and buffers the result in a small FIFO.
- Used by the self-test program generator and the boot loader to write instruction memory.

Parameters:
- FIFO_DEPTH, 4, output buffer entries (power of 2, ≥2)
- ADDR_W, 32, issue-address width
- CNT_W, 16, width of the saturating statistics counters

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  encode request valid
- in_ready  out  1  request accepted when in_valid&&in_ready
- in_fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=R4, 7=reserved
- in_opcode  in  7  major opcode
- in_rd, in_rs1, in_rs2, in_rs3  in  5 each  register indices
- in_funct3  in  3  funct3 / rm
- in_funct7  in  7  funct7; R4 uses bits [1:0] as fmt
- in_imm  in  32  immediate as a full signed byte value (U: full value, low 12 bits must be 0)
- load_base  in  1  load issue-address counter
- base_addr  in  ADDR_W  value loaded by load_base
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_instr  out  32  encoded word
- out_addr  out  ADDR_W  issue address of head word
- out_err  out  1  head word was replaced by NOP
- enc_count  out  CNT_W  accepted requests, saturating
- err_count  out  CNT_W  illegal requests, saturating

Behaviour:
- Reset (async): FIFO empty; out_valid=0; out_instr=0; out_addr=0; out_err=0; issue counter=0; both counters=0; in_ready=1 once rst deasserts.
- Handshake:
  - in_ready = (occupancy < FIFO_DEPTH), registered-state only; no combinational path from out_ready.
  - out_valid = occupancy != 0.
  - Pop on out_valid&&out_ready. Simultaneous push and pop keeps occupancy unchanged.
- Latency: word accepted in cycle N is visible at the FIFO head in N+1 at the earliest. Ordering is strictly FIFO.
- Encoding follows standard RV32 bit placement per format. R4: rs3[31:27], fmt[26:25], rs2, rs1, rm[14:12], rd.
- Legality; any failure emits NOP 0x00000013 with err=1:
  - fmt=7.
  - I/S imm not in [-2048, 2047].
  - B imm not in [-4096, 4094] or odd.
  - J imm not in [-1048576, 1048574] or odd.
  - U imm[11:0] != 0.
  - opcode[1:0] != 2'b11.
- Issue address:
  - Each accepted request is tagged with the current counter value; the counter then increments by 4, wrapping modulo 2^ADDR_W.
  - load_base loads base_addr. If load_base coincides with an accept, the accepted word gets base_addr and the counter becomes base_addr+4.
  - Entries already in the FIFO keep their tags.
- Counters:
  - enc_count increments on every accept, including illegal ones.
  - err_count increments on illegal accepts.
  - Both saturate at all-ones.
- Reset mid-stream discards all FIFO contents and counters immediately.

Optional Feature:
- Macro: ENC_FPU_EN.
- Defined: fmt=6 (R4) and F opcodes 0000111, 0100111, 1000011, 1000111, 1001011, 1001111, 1010011 are legal.
- Undefined: any request with fmt=6 or one of those opcodes is illegal (NOP, err=1, err_count++). The R4 packing logic is not synthesized.

Decomposition:
- Shared package rv_isa_pkg holds:
  - format code constants FMT_R..FMT_R4;
  - all RV32I/M/F opcode constants (shared with the decoder);
  - NOP_INSTR = 32'h00000013.
- Sub-module rv_enc_fifo: parameterized synchronous FIFO with async active-high reset, carrying {err, addr, instr}.
- The combinational packer/checker stays inside rv_instr_encoder.

Test Plan:
- ADDI x1,x0,5 (fmt I, op 0010011, imm 5), out_ready=1 -> next cycle out_instr=0x00500093, out_addr=0, out_err=0.
- ADD x3,x1,x2 then SW x2,8(x1) back-to-back -> 0x002081B3 @0, 0x0020A423 @4.
- BEQ x0,x0,-4 after load_base with base_addr=0x100 in the same cycle -> 0xFE000EE3 @0x100; next request tagged 0x104.
- ADDI with imm=4096 -> 0x00000013, out_err=1, err_count=1, enc_count increments.
- Backpressure: out_ready=0, push 5 requests -> in_ready drops after the 4th; the 5th is held; release out_ready -> 5 words drain in order with addresses +4 apart.
- FMADD.S f1,f2,f3,f4, rm=0: with ENC_FPU_EN -> 0x203100C3, err=0; without the macro -> 0x00000013, err=1.

Source files
------------

// File: rtl/rv_isa_pkg.sv
// ---------------------------------------------------------------------------
// rv_isa_pkg
//
// Shared RV32IMF definitions used by the instruction encoder and the main
// opcode decoder.
//
// Contents:
//   instr_fmt_e   - encode-request format codes (FMT_R .. FMT_R4, FMT_RSVD)
//   OP_*          - RV32I / M / F major opcodes
//   F7_MULDIV     - funct7 value that selects the M extension under OP_OP
//   FP_FMT_*      - R4 floating-point fmt field values
//   NOP_INSTR     - canonical NOP (ADDI x0,x0,0)
//   isFpOpcode()  - true for the seven F-extension major opcodes
// ---------------------------------------------------------------------------
package rv_isa_pkg;

    // Format codes carried on the encode-request interface.
    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_R4   = 3'd6,
        FMT_RSVD = 3'd7
    } instr_fmt_e;

    // RV32I major opcodes.
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    // RV32F major opcodes.
    localparam logic [6:0] OP_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OP_STORE_FP = 7'b0100111;
    localparam logic [6:0] OP_FMADD    = 7'b1000011;
    localparam logic [6:0] OP_FMSUB    = 7'b1000111;
    localparam logic [6:0] OP_FNMSUB   = 7'b1001011;
    localparam logic [6:0] OP_FNMADD   = 7'b1001111;
    localparam logic [6:0] OP_OP_FP    = 7'b1010011;

    // The M extension reuses OP_OP and is told apart by funct7.
    localparam logic [6:0] F7_MULDIV   = 7'b0000001;

    // R4 fmt field values (single / double precision).
    localparam logic [1:0] FP_FMT_S    = 2'b00;
    localparam logic [1:0] FP_FMT_D    = 2'b01;

    // ADDI x0,x0,0 -- emitted in place of any request that fails a check.
    localparam logic [31:0] NOP_INSTR  = 32'h00000013;

    // Identifies the opcodes that only exist when the F extension is present.
    function automatic logic isFpOpcode(input logic [6:0] opcode);
        logic result;
        case (opcode)
            OP_LOAD_FP, OP_STORE_FP, OP_FMADD, OP_FMSUB,
            OP_FNMSUB, OP_FNMADD, OP_OP_FP: result = 1'b1;
            default:                        result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/rv_enc_fifo.sv
// ---------------------------------------------------------------------------
// rv_enc_fifo
//
// Small synchronous FIFO that buffers encoded words for the consumer. The
// head entry is presented combinationally from storage, so a word written in
// cycle N is readable in cycle N+1. Storage is cleared on reset so the head
// reads as all-zero while the FIFO is empty after reset.
//
// Parameters:
//   DEPTH  - number of entries (power of two, >= 2)
//   WIDTH  - entry width in bits
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   asynchronous active-high reset
//   i_push  in   write i_data (ignored while full)
//   i_data  in   entry to write
//   o_full  out  no free entry; depends on registered state only
//   i_pop   in   discard head entry (ignored while empty)
//   o_data  out  head entry
//   o_empty out  no valid entry
// ---------------------------------------------------------------------------
module rv_enc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty
);

    localparam int             PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0] CNT_ONE    = (PTR_W + 1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W:0]   r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign o_full   = (r_count == FULL_COUNT);
    assign o_empty  = (r_count == '0);
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;
    assign o_data   = r_mem[r_rdPtr];

    // Entry storage. Only the slot under the write pointer changes on a push;
    // pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping. A simultaneous push and pop moves
    // both pointers and leaves the occupancy unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/rv_instr_encoder.sv
// ---------------------------------------------------------------------------
// rv_instr_encoder
//
// Streaming RV32IMF instruction encoder: the inverse of the opcode decoder.
// Field-level requests are range-checked, packed into 32-bit words, tagged
// with an issue address and buffered in rv_enc_fifo. A request that fails any
// check is still accepted but is emitted as NOP with the error flag set.
//
// Build option:
//   ENC_FPU_EN  - when defined, R4 format and the F-extension opcodes are
//                 legal and the R4 packer is built. When undefined, any such
//                 request is emitted as NOP/error.
//
// Parameters:
//   FIFO_DEPTH - output buffer entries (power of two, >= 2)
//   ADDR_W     - issue-address width
//   CNT_W      - width of the saturating statistics counters
//
// Ports:
//   clk, rst          clock (rising edge) / async active-high reset
//   in_valid/in_ready encode-request handshake; in_ready depends only on
//                     registered FIFO occupancy
//   in_fmt            0=R 1=I 2=S 3=B 4=U 5=J 6=R4 7=reserved
//   in_opcode         major opcode
//   in_rd..in_rs3     register indices
//   in_funct3         funct3 / rounding mode
//   in_funct7         funct7; bits [1:0] are the R4 fmt field
//   in_imm            immediate as a full signed byte value
//   load_base         load the issue-address counter from base_addr
//   base_addr         value loaded by load_base
//   out_valid/ready   FIFO head handshake
//   out_instr         encoded word at the head
//   out_addr          issue address of the head word
//   out_err           head word was replaced by NOP
//   enc_count         accepted requests, saturating
//   err_count         illegal requests, saturating
// ---------------------------------------------------------------------------
module rv_instr_encoder
    import rv_isa_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rs3,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    input  logic              load_base,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [CNT_W-1:0]  enc_count,
    output logic [CNT_W-1:0]  err_count
);

    localparam int ENTRY_W = 1 + ADDR_W + 32;

    instr_fmt_e          w_fmt;
    logic [31:0]         w_packed;
    logic                w_fmtBad;
    logic                w_opBad;
    logic                w_fpBad;
    logic                w_illegal;
    logic [31:0]         w_instr;
    logic                w_immFits12;
    logic                w_immFits13;
    logic                w_immFits21;
    logic                w_accept;
    logic [ADDR_W-1:0]   w_tag;
    logic                w_fifoFull;
    logic                w_fifoEmpty;
    logic [ENTRY_W-1:0]  w_fifoDin;
    logic [ENTRY_W-1:0]  w_fifoDout;

    logic [ADDR_W-1:0]   r_issueAddr;
    logic [CNT_W-1:0]    r_encCount;
    logic [CNT_W-1:0]    r_errCount;

    assign w_fmt = instr_fmt_e'(in_fmt);

    // A value fits an N-bit signed field when every bit above N-2 equals the
    // sign bit, i.e. bits [31:N-1] are all ones or all zeros.
    assign w_immFits12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign w_immFits13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign w_immFits21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

    // Format packer and per-format immediate checks. B and J immediates are
    // byte offsets of halfword-aligned targets, so bit 0 is dropped from the
    // word and must be zero; U takes the upper 20 bits of a full value whose
    // low 12 bits must already be clear.
    always_comb begin
        w_packed = NOP_INSTR;
        w_fmtBad = 1'b0;
        case (w_fmt)
            FMT_R: begin
                w_packed = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            end
            FMT_I: begin
                w_packed = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                w_fmtBad = !w_immFits12;
            end
            FMT_S: begin
                w_packed = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:0], in_opcode};
                w_fmtBad = !w_immFits12;
            end
            FMT_B: begin
                w_packed = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_opcode};
                w_fmtBad = !w_immFits13 || in_imm[0];
            end
            FMT_U: begin
                w_packed = {in_imm[31:12], in_rd, in_opcode};
                w_fmtBad = |in_imm[11:0];
            end
            FMT_J: begin
                w_packed = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                            in_rd, in_opcode};
                w_fmtBad = !w_immFits21 || in_imm[0];
            end
            FMT_R4: begin
`ifdef ENC_FPU_EN
                w_packed = {in_rs3, in_funct7[1:0], in_rs2, in_rs1, in_funct3,
                            in_rd, in_opcode};
`else
                w_fmtBad = 1'b1;
`endif
            end
            default: begin
                w_fmtBad = 1'b1;
            end
        endcase
    end

    // Every 32-bit RV instruction has opcode[1:0] = 2'b11; anything else
    // belongs to the compressed space and cannot be produced here.
    assign w_opBad = (in_opcode[1:0] != 2'b11);

`ifdef ENC_FPU_EN
    assign w_fpBad = 1'b0;
`else
    // Without the FPU the F opcodes are illegal in any format, and rs3 only
    // feeds the R4 packer, which is not built.
    logic [4:0] w_unusedRs3;
    assign w_unusedRs3 = in_rs3;
    assign w_fpBad     = isFpOpcode(in_opcode);
`endif

    assign w_illegal = w_fmtBad | w_opBad | w_fpBad;
    assign w_instr   = w_illegal ? NOP_INSTR : w_packed;

    // Handshake and tagging. A load_base in the same cycle as an accept
    // overrides the running counter for that word.
    assign in_ready  = !w_fifoFull;
    assign w_accept  = in_valid && in_ready;
    assign w_tag     = load_base ? base_addr : r_issueAddr;
    assign w_fifoDin = {w_illegal, w_tag, w_instr};

    rv_enc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_accept),
        .i_data  (w_fifoDin),
        .o_full  (w_fifoFull),
        .i_pop   (out_ready),
        .o_data  (w_fifoDout),
        .o_empty (w_fifoEmpty)
    );

    assign out_valid = !w_fifoEmpty;
    assign out_instr = w_fifoDout[31:0];
    assign out_addr  = w_fifoDout[ADDR_W+31:32];
    assign out_err   = w_fifoDout[ADDR_W+32];

    // Issue-address counter: advances by one word after each accept, wrapping
    // modulo 2^ADDR_W, and can be reloaded at any time. Entries already in
    // the FIFO keep the tag they were written with.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issueAddr <= '0;
        end else if (w_accept) begin
            r_issueAddr <= w_tag + ADDR_W'(4);
        end else if (load_base) begin
            r_issueAddr <= base_addr;
        end
    end

    // Statistics counters. Illegal requests still count as accepted; both
    // counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_encCount <= '0;
            r_errCount <= '0;
        end else if (w_accept) begin
            if (r_encCount != '1) begin
                r_encCount <= r_encCount + CNT_W'(1);
            end
            if (w_illegal && (r_errCount != '1)) begin
                r_errCount <= r_errCount + CNT_W'(1);
            end
        end
    end

    assign enc_count = r_encCount;
    assign err_count = r_errCount;

endmodule
